uart_ctrl: RTL and testbench

- Memory-mapped controller sequencing the UART receiver and transmitter for the CPU data bus.
- Captures completed RX bytes into a holding register with sticky overrun.
- Buffers CPU TX writes in a small FIFO and launches them one at a time through a tx_en/tx_busy handshake.
- Sits between the data-memory bus decode and the baud-rate-clocked UART RX/TX blocks.

---
 rtl/uart_ctrl_if.sv | 24 ++
 rtl/uart_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_uart_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_if.sv
// Bus and UART-side signal bundle for uart_ctrl; slave = the controller, master = CPU bus decode plus UART RX/TX.
interface uart_ctrl_if;
    logic [31:0] addr;
    logic        rd;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  rx_data;
    logic        rx_status;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic        irq;

    modport slave (
        input  addr, rd, we, wdata, rx_data, rx_status, tx_busy,
        output rdata, tx_data, tx_en, irq
    );

    modport master (
        output addr, rd, we, wdata, rx_data, rx_status, tx_busy,
        input  rdata, tx_data, tx_en, irq
    );
endinterface

// File: rtl/uart_ctrl.sv
// Memory-mapped UART controller: RX holding register with sticky overrun, TX FIFO drained by a launch/ack FSM.
// Optional macro UART_IRQ_EN adds a registered interrupt and the CON[6] irq_en bit.
module uart_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h4000_0018,
    parameter int          TX_DEPTH    = 4,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    uart_ctrl_if.slave  bus
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] DEPTH_C   = CW'(TX_DEPTH);
    localparam logic [TW-1:0] TIMEOUT_C = TW'(ACK_TIMEOUT);

    localparam logic [29:0] RXD_W = BASE_ADDR[31:2];
    localparam logic [29:0] TXD_W = RXD_W + 30'd1;
    localparam logic [29:0] CON_W = RXD_W + 30'd2;

    localparam logic [1:0] TX_IDLE      = 2'd0;
    localparam logic [1:0] TX_LAUNCH    = 2'd1;
    localparam logic [1:0] TX_WAIT_ACK  = 2'd2;
    localparam logic [1:0] TX_WAIT_DONE = 2'd3;

    logic hit_rxd, hit_txd, hit_con;
    logic rxd_read, txd_wr, con_wr;

    assign hit_rxd  = (bus.addr[31:2] == RXD_W);
    assign hit_txd  = (bus.addr[31:2] == TXD_W);
    assign hit_con  = (bus.addr[31:2] == CON_W);
    assign rxd_read = bus.rd & hit_rxd;
    assign txd_wr   = bus.we & hit_txd;
    assign con_wr   = bus.we & hit_con;

    logic rx_s1, rx_s2, rx_s3;
    logic busy_s1, busy_s2;
    logic rx_capture;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1   <= 1'b0;
            rx_s2   <= 1'b0;
            rx_s3   <= 1'b0;
            busy_s1 <= 1'b0;
            busy_s2 <= 1'b0;
        end else begin
            rx_s1   <= bus.rx_status;
            rx_s2   <= rx_s1;
            rx_s3   <= rx_s2;
            busy_s1 <= bus.tx_busy;
            busy_s2 <= busy_s1;
        end
    end

    assign rx_capture = rx_s2 & ~rx_s3;

    logic [7:0] hold;
    logic       rx_valid;
    logic       rx_overrun;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold       <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_capture) begin
                hold     <= bus.rx_data;
                rx_valid <= 1'b1;
            end else if (rxd_read) begin
                rx_valid <= 1'b0;
            end
            // A read in the capture cycle consumes the old byte, so no overrun.
            if (rx_capture && rx_valid && !rxd_read)
                rx_overrun <= 1'b1;
            else if (con_wr && bus.wdata[3])
                rx_overrun <= 1'b0;
        end
    end

    logic [7:0]    mem [TX_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          tx_full, tx_empty, push, pop, drop_push;
    logic [1:0]    state;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          tx_drop;

    assign tx_full   = (count == DEPTH_C);
    assign tx_empty  = (count == '0);
    assign push      = txd_wr & ~tx_full;
    assign drop_push = txd_wr & tx_full;
    assign pop       = (state == TX_IDLE) & ~tx_empty;
    assign timeout   = (state == TX_WAIT_ACK) & ~busy_s2 & (to_cnt == TIMEOUT_C);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= TX_IDLE;
            bus.tx_data <= 8'h00;
            to_cnt      <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    if (pop) begin
                        bus.tx_data <= mem[rd_ptr];
                        state       <= TX_LAUNCH;
                    end
                end
                TX_LAUNCH: begin
                    to_cnt <= '0;
                    state  <= TX_WAIT_ACK;
                end
                TX_WAIT_ACK: begin
                    if (busy_s2)
                        state <= TX_WAIT_DONE;
                    else if (timeout)
                        state <= TX_IDLE;
                    else
                        to_cnt <= to_cnt + TW'(1);
                end
                default: begin
                    if (!busy_s2)
                        state <= TX_IDLE;
                end
            endcase
        end
    end

    assign bus.tx_en = (state == TX_LAUNCH);

    always_ff @(posedge clk) begin
        if (reset)
            tx_drop <= 1'b0;
        else if (drop_push || timeout)
            tx_drop <= 1'b1;
        else if (con_wr && bus.wdata[4])
            tx_drop <= 1'b0;
    end

    logic irq_en;

`ifdef UART_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (con_wr)
                irq_en_q <= bus.wdata[6];
            irq_q <= irq_en_q & (rx_valid | (tx_empty & (state == TX_IDLE)));
        end
    end

    assign irq_en  = irq_en_q;
    assign bus.irq = irq_q;
`else
    assign irq_en  = 1'b0;
    assign bus.irq = 1'b0;
`endif

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.rd) begin
            if (hit_rxd)
                bus.rdata = {24'h0, hold};
            else if (hit_con)
                bus.rdata = {24'h0, 1'b0, irq_en, (state != TX_IDLE), tx_drop,
                             rx_overrun, tx_empty, tx_full, rx_valid};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:8], bus.wdata[5], bus.wdata[2:0]};

endmodule

// File: tb/tb_uart_ctrl.sv
// Directed self-checking bench for uart_ctrl with a simple transmitter model (busy 2 cycles after tx_en, 20 cycles long).
module tb_uart_ctrl;
    localparam logic [31:0] RXD = 32'h4000_0018;
    localparam logic [31:0] TXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;
`ifdef UART_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_ctrl_if bus();
    uart_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    int n_chk = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int n_pulse = 0;
    logic dbl = 1'b0;
    logic prev_en = 1'b0;
    logic no_ack = 1'b0;
    logic [7:0] tx_log [$];
    int t_log [$];
    logic [31:0] d;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] data);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1 data = bus.rdata;
        @(posedge clk);
        #1;
        bus.rd   = 1'b0;
        bus.addr = 32'h0;
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] data);
        bus.addr = a;
        bus.rd   = 1'b1;
        #1 data = bus.rdata;
        bus.rd   = 1'b0;
        bus.addr = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
        bus.addr  = a;
        bus.wdata = v;
        bus.we    = 1'b1;
        @(posedge clk);
        #1;
        bus.we    = 1'b0;
        bus.addr  = 32'h0;
        bus.wdata = 32'h0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        bus.rx_data   = b;
        bus.rx_status = 1'b1;
        repeat (4) cyc();
        bus.rx_status = 1'b0;
        repeat (4) cyc();
    endtask

    // Launch monitor: logs every tx_en pulse and flags back-to-back pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1) begin
                n_pulse++;
                tx_log.push_back(bus.tx_data);
                t_log.push_back(cyc_cnt);
                if (prev_en) dbl = 1'b1;
            end
            prev_en = (bus.tx_en === 1'b1);
        end
    end

    // Transmitter model.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.tx_en === 1'b1 && !no_ack) begin
                repeat (2) @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (20) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    initial begin
        bus.addr = 32'h0; bus.rd = 1'b0; bus.we = 1'b0; bus.wdata = 32'h0;
        bus.rx_data = 8'h00; bus.rx_status = 1'b0;

        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();
        check("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        check("rst_tx_en", {31'h0, bus.tx_en}, 32'h0);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);
        peek(CON, d);      check("rst_con", d, 32'h4);
        repeat (5) cyc();
        check("rst_no_pulse", n_pulse, 0);

        // RX capture latency
        bus.rx_data = 8'hA5; bus.rx_status = 1'b1;
        cyc(); cyc();
        peek(CON, d);      check("rx_not_yet", d, 32'h4);
        cyc();
        peek(CON, d);      check("rx_valid_set", d, 32'h5);
        bus_read(RXD, d);  check("rxd_a5", d, 32'hA5);
        peek(CON, d);      check("rx_valid_clr", d, 32'h4);
        bus.rx_status = 1'b0;
        repeat (4) cyc();

        // Overrun
        rx_pulse(8'h11);
        rx_pulse(8'h22);
        peek(CON, d);      check("overrun_con", d, 32'hD);
        bus_read(RXD, d);  check("overrun_rxd", d, 32'h22);
        bus_write(CON, 32'h8);
        peek(CON, d);      check("overrun_clr", d, 32'h4);

        // Capture and RXD read in the same cycle
        rx_pulse(8'h33);
        bus.rx_data = 8'h44; bus.rx_status = 1'b1;
        cyc(); cyc();
        bus_read(RXD, d);  check("simul_old", d, 32'h33);
        peek(CON, d);      check("simul_con", d, 32'h5);
        bus.rx_status = 1'b0;
        repeat (4) cyc();
        bus_read(RXD, d);  check("simul_new", d, 32'h44);

        // TX: prime frame holds the FSM in WAIT_DONE, then fill the FIFO and overflow
        bus_write(TXD, 32'hF0);
        repeat (8) cyc();
        for (int i = 1; i <= 5; i++) bus_write(TXD, i);
        peek(CON, d);      check("tx_full_drop", d, 32'h32);
        bus_read(TXD, d);  check("txd_read_zero", d, 32'h0);
        repeat (250) cyc();
        check("tx_pulses", n_pulse, 5);
        for (int i = 0; i < 5; i++)
            check("tx_seq", (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hFFFF_FFFF,
                  (i == 0) ? 32'hF0 : i);
        check("tx_en_single", {31'h0, dbl}, 32'h0);
        peek(CON, d);      check("tx_drained", d, 32'h14);
        bus_write(CON, 32'h10);
        peek(CON, d);      check("drop_clr", d, 32'h4);

        // Ack timeout
        no_ack = 1'b1;
        bus_write(TXD, 32'hAA);
        bus_write(TXD, 32'hBB);
        repeat (20) cyc();
        check("to_first_launch", n_pulse, 6);
        peek(CON, d);      check("to_waiting", d, 32'h20);
        repeat (300) cyc();
        check("to_second_launch", n_pulse, 7);
        check("to_next_byte", (tx_log.size() > 6) ? {24'h0, tx_log[6]} : 32'hFFFF_FFFF, 32'hBB);
        check("to_interval", (t_log.size() > 6 && t_log[6] - t_log[5] >= 255 &&
                              t_log[6] - t_log[5] <= 260) ? 32'h1 : 32'h0, 32'h1);
        peek(CON, d);      check("to_drop_busy", d, 32'h34);
        repeat (300) cyc();
        peek(CON, d);      check("to_idle", d, 32'h14);
        bus_write(CON, 32'h10);

        // Interrupt: keep FSM out of idle so only rx_valid drives irq
        bus_write(TXD, 32'h77);
        repeat (5) cyc();
        bus_write(CON, 32'h40);
        peek(CON, d);      check("irq_en_bit", d, IRQ ? 32'h64 : 32'h24);
        check("irq_quiet", {31'h0, bus.irq}, 32'h0);
        bus.rx_data = 8'h5A; bus.rx_status = 1'b1;
        repeat (4) cyc();
        check("irq_rx", {31'h0, bus.irq}, {31'h0, IRQ});
        bus.rx_status = 1'b0;
        bus_read(RXD, d);  check("irq_rxd", d, 32'h5A);
        check("irq_lag", {31'h0, bus.irq}, {31'h0, IRQ});
        cyc();
        check("irq_clr", {31'h0, bus.irq}, 32'h0);
        repeat (300) cyc();
        check("irq_tx_idle", {31'h0, bus.irq}, {31'h0, IRQ});
        bus_write(CON, 32'h10);
        cyc();
        check("irq_disable", {31'h0, bus.irq}, 32'h0);
        peek(CON, d);      check("irq_con_end", d, 32'h4);
        no_ack = 1'b0;

        // Unmapped addresses
        bus_write(CON + 32'd4, 32'hFF);
        peek(CON, d);      check("unmapped_wr", d, 32'h4);
        bus_read(CON + 32'd4, d); check("unmapped_rd_hi", d, 32'h0);
        bus_read(RXD - 32'd4, d); check("unmapped_rd_lo", d, 32'h0);

        // Reset mid-operation discards queued bytes
        bus_write(TXD, 32'h31);
        bus_write(TXD, 32'h32);
        bus_write(TXD, 32'h33);
        repeat (8) cyc();
        check("mid_first_launch", n_pulse, 9);
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        peek(CON, d);      check("mid_rst_con", d, 32'h4);
        check("mid_rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
        repeat (120) cyc();
        check("mid_no_relaunch", n_pulse, 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
